// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
//
// Shared constants for the multiplexed 7-segment display path.
//
//   HEX_SEG_TABLE : active-low {a,b,c,d,e,f,g} pattern for each hex digit 0-F
//   SEG_OFF       : all eight cathodes (segments + dp) released
//   DP_BIT        : position of the decimal point in the 8-bit segment bus
//   ANODE_OFF     : all anodes released, sized for the largest supported bank
//   idx_width()   : width of a scan index for a bank of n digits (min 1 bit)
// -----------------------------------------------------------------------------
package display_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam int         DP_BIT  = 0;

    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    // Common-anode patterns: a cleared bit lights the segment.
    // Bit order is a (MSB) .. g (LSB).
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h01,  // 0
        7'h4F,  // 1
        7'h12,  // 2
        7'h06,  // 3
        7'h4C,  // 4
        7'h24,  // 5
        7'h20,  // 6
        7'h0F,  // 7
        7'h00,  // 8
        7'h04,  // 9
        7'h08,  // A
        7'h60,  // b
        7'h31,  // C
        7'h42,  // d
        7'h30,  // E
        7'h38   // F
    };

    // A single-digit bank still needs a 1-bit index to keep the
    // declarations legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex2seg.sv
// -----------------------------------------------------------------------------
// hex2seg
//
// Converts a 4-bit hex number into its active-low 7-segment pattern.
//
// Ports:
//   nibble : in  [3:0]  hex digit to show
//   seg    : out [6:0]  {a,b,c,d,e,f,g}, active-low
// -----------------------------------------------------------------------------
module hex2seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/scan_display_ctrl.sv
// -----------------------------------------------------------------------------
// scan_display_ctrl
//
// Time-multiplexed driver for a bank of common-anode 7-segment digits.
// Each digit owns one slot of 2^PRESCALE_LOG2 clocks, and the slots repeat
// as a frame. A new value is captured into a pending buffer and becomes
// visible only at a frame boundary, so a frame never shows a mix of old and
// new digits. Decimal points, leading-zero suppression, per-digit blink and
// PWM brightness are applied on top of the shown value.
//
// Parameters:
//   NUM_DIGITS        : digits scanned (1..8)
//   PRESCALE_LOG2     : log2 of clocks per digit slot
//   BRIGHT_W          : brightness width, must not exceed PRESCALE_LOG2
//   BLINK_FRAMES_LOG2 : log2 of frames per blink half-period (>= 1)
//
// Ports:
//   clock       : in   system clock
//   reset       : in   asynchronous reset, active-low
//   value       : in   [4*NUM_DIGITS-1:0] hex value, nibble i -> digit i
//   load        : in   capture value into the pending buffer
//   dp          : in   [NUM_DIGITS-1:0] decimal point per digit, active-high
//   lz_en       : in   leading-zero suppression enable
//   blink_mask  : in   [NUM_DIGITS-1:0] 1 = digit blinks
//   brightness  : in   [BRIGHT_W-1:0] PWM duty, 0 = 1/2^BRIGHT_W, max = full
//   disp_en     : in   0 blanks the whole display
//   digit       : out  [NUM_DIGITS-1:0] anode enables, active-low, registered
//   segment     : out  [7:0] {a,b,c,d,e,f,g,dp}, active-low, registered
//   pending     : out  a captured value is waiting for the next frame
//   frame_start : out  one-cycle pulse at the start of the digit-0 slot
// -----------------------------------------------------------------------------
module scan_display_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS        = 8,
    parameter int PRESCALE_LOG2     = 11,
    parameter int BRIGHT_W          = 4,
    parameter int BLINK_FRAMES_LOG2 = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    lz_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    disp_en,
    output logic [NUM_DIGITS-1:0]   digit,
    output logic [7:0]              segment,
    output logic                    pending,
    output logic                    frame_start
);

    localparam int                    IDX_W      = idx_width(NUM_DIGITS);
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIGITS_OFF = ANODE_OFF[NUM_DIGITS-1:0];

    // -------------------------------------------------------------------------
    // Scan timing
    // -------------------------------------------------------------------------
    logic [PRESCALE_LOG2-1:0]     cnt;
    logic [IDX_W-1:0]             idx;
    logic                         tick;
    logic                         frame_wrap;

    assign tick       = &cnt;
    assign frame_wrap = tick && (idx == LAST_IDX);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx <= '0;
        end else if (tick) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Double buffer
    // -------------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] active;
    logic [4*NUM_DIGITS-1:0] pending_buf;

    // NOTE: both buffers are plain registers, not memories, and are cleared by
    // reset so a blank display follows reset rather than random segments.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active      <= '0;
            pending_buf <= '0;
            pending     <= 1'b0;
        end else begin
            if (load) begin
                pending_buf <= value;
            end

            // A load landing on the frame boundary would otherwise sit in the
            // pending buffer for a whole extra frame; take it straight through.
            if (load && frame_wrap) begin
                active  <= value;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end else if (frame_wrap && pending) begin
                active  <= pending_buf;
                pending <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Blink phase: toggles every 2^BLINK_FRAMES_LOG2 frames
    // -------------------------------------------------------------------------
    logic [BLINK_FRAMES_LOG2-1:0] blink_cnt;
    logic                         blink_phase;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_wrap) begin
            blink_cnt <= blink_cnt + 1'b1;
            if (&blink_cnt) begin
                blink_phase <= ~blink_phase;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Leading-zero map: bit i set when nibbles i..top of active are all zero.
    // Bit 0 stays clear so a zero value still shows one "0".
    // -------------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] lz_blank_vec;

    // NOTE: every combinational output gets a default before any branch or
    // loop, so no path leaves a value held and no latch is inferred.
    always_comb begin
        logic upper_zero;
        lz_blank_vec = '0;
        upper_zero   = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            upper_zero      = upper_zero & (active[4*i +: 4] == 4'h0);
            lz_blank_vec[i] = upper_zero;
        end
    end

    // -------------------------------------------------------------------------
    // Per-cycle blank decision and segment decode for the current slot
    // -------------------------------------------------------------------------
    logic [3:0] cur_nibble;
    logic [6:0] cur_pattern;
    logic       lz_sup;
    logic       blink_off;
    logic       lit;
    logic       blank;

    assign cur_nibble = active[4*idx +: 4];

    hex2seg u_hex2seg (
        .nibble (cur_nibble),
        .seg    (cur_pattern)
    );

    assign lz_sup    = lz_en & lz_blank_vec[idx];
    assign blink_off = blink_phase & blink_mask[idx];
    // PWM: compare the top bits of the slot counter against the duty level,
    // so the lit window is always at the start of each slot.
    assign lit       = (cnt[PRESCALE_LOG2-1 -: BRIGHT_W] <= brightness);
    assign blank     = !disp_en || lz_sup || blink_off || !lit;

    logic [NUM_DIGITS-1:0] digit_d;
    logic [7:0]            segment_d;

    always_comb begin
        digit_d   = DIGITS_OFF;
        segment_d = SEG_OFF;
        if (!blank) begin
            digit_d[idx]      = 1'b0;
            segment_d[7:1]    = cur_pattern;
            segment_d[DP_BIT] = ~dp[idx];
        end
    end

    // Registered pin drivers: one clean transition per clock, and at most one
    // anode enabled because digit_d has at most one cleared bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            digit       <= DIGITS_OFF;
            segment     <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            digit       <= digit_d;
            segment     <= segment_d;
            frame_start <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_scan_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scan_display_ctrl
//
// Bench for scan_display_ctrl with a 4-digit bank, 16-clock slots, 2-bit
// brightness and a 2-frame blink half-period.
//
// The reference model works from elapsed clock edges since reset: slot, digit
// and frame numbers come from division, the shown value is the last load made
// at or before the edge that opened the current frame, and the blink phase is
// the frame number divided by the half-period. Expected outputs are queued at
// each clock edge and a separate monitor compares them on the falling edge.
// -----------------------------------------------------------------------------
module tb_scan_display_ctrl;

    localparam int ND    = 4;
    localparam int PL    = 4;
    localparam int BW    = 2;
    localparam int BL    = 1;
    localparam int SLOT  = 1 << PL;
    localparam int FRAME = SLOT * ND;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   value;
    logic          load;
    logic [3:0]    dp;
    logic          lz_en;
    logic [3:0]    blink_mask;
    logic [BW-1:0] brightness;
    logic          disp_en;
    logic [3:0]    digit;
    logic [7:0]    segment;
    logic          pending;
    logic          frame_start;

    always #5 clk = ~clk;

    scan_display_ctrl #(
        .NUM_DIGITS        (ND),
        .PRESCALE_LOG2     (PL),
        .BRIGHT_W          (BW),
        .BLINK_FRAMES_LOG2 (BL)
    ) dut (
        .clock       (clk),
        .reset       (rst_n),
        .value       (value),
        .load        (load),
        .dp          (dp),
        .lz_en       (lz_en),
        .blink_mask  (blink_mask),
        .brightness  (brightness),
        .disp_en     (disp_en),
        .digit       (digit),
        .segment     (segment),
        .pending     (pending),
        .frame_start (frame_start)
    );

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    typedef struct {
        int         k;
        logic [3:0] digit;
        logic [7:0] seg;
        logic       pend;
        logic       fs;
    } exp_t;

    typedef struct {
        int          edge_no;
        logic [15:0] val;
    } load_t;

    exp_t  sb[$];
    load_t hist[$];
    int    k;
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string name, input int tag,
                         input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %h, expected %h", name, tag, act, exp);
        end
    endtask

    // Lit segments of a hex digit, active-high, order a..g.
    function automatic logic [6:0] lit_segs(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    // Value shown while the DUT sits s edges after reset.
    function automatic logic [15:0] active_for(input int s);
        int          f0;
        logic [15:0] v;
        f0 = (s / FRAME) * FRAME;
        v  = 16'h0;
        foreach (hist[j]) begin
            if (hist[j].edge_no <= f0) v = hist[j].val;
        end
        return v;
    endfunction

    // A load is waiting if one happened since the edge that opened the frame.
    function automatic logic pending_for(input int kk);
        int f0;
        f0 = (kk / FRAME) * FRAME;
        foreach (hist[j]) begin
            if (hist[j].edge_no > f0 && hist[j].edge_no <= kk) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Outputs after edge kk reflect the position before that edge (kk-1)
    // together with the live inputs sampled at that edge.
    function automatic exp_t predict(input int kk);
        exp_t        e;
        int          s;
        int          c;
        int          i;
        int          f;
        logic [15:0] act;
        logic [3:0]  nib;
        logic        blank;
        s   = kk - 1;
        c   = s % SLOT;
        i   = (s / SLOT) % ND;
        f   = s / FRAME;
        act = active_for(s);
        nib = act[4*i +: 4];
        blank = !disp_en
             || (lz_en && i > 0 && (act >> (4 * i)) == 16'h0)
             || (blink_mask[i] && ((f >> BL) & 1) == 1)
             || ((c >> (PL - BW)) > int'(brightness));
        e.k     = kk;
        e.digit = blank ? 4'hF : ~(4'b0001 << i);
        e.seg   = blank ? 8'hFF : {~lit_segs(nib), ~dp[i]};
        e.pend  = pending_for(kk);
        e.fs    = (kk % FRAME) == 0;
        return e;
    endfunction

    // Model: one expectation per clock edge.
    initial begin
        exp_t e;
        k = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                k = 0;
                hist.delete();
                e.k = 0; e.digit = 4'hF; e.seg = 8'hFF; e.pend = 1'b0; e.fs = 1'b0;
                sb.push_back(e);
            end else begin
                load_t l;
                k++;
                if (load) begin
                    l.edge_no = k;
                    l.val     = value;
                    hist.push_back(l);
                end
                sb.push_back(predict(k));
            end
        end
    end

    // Monitor: compares on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("digit",       e.k, 8'(digit),       8'(e.digit));
                check("segment",     e.k, segment,         e.seg);
                check("pending",     e.k, 8'(pending),     8'(e.pend));
                check("frame_start", e.k, 8'(frame_start), 8'(e.fs));
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        step(1);
        load  = 1'b0;
    endtask

    // Advance until the edge count within the frame equals m (bounded).
    task automatic wait_k_mod(input int m);
        for (int n = 0; n < FRAME && (k % FRAME) != m; n++) step(1);
    endtask

    initial begin
        rst_n      = 1'b0;
        load       = 1'b0;
        value      = 16'h0;
        dp         = 4'b0000;
        lz_en      = 1'b0;
        blink_mask = 4'b0000;
        brightness = 2'd3;
        disp_en    = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(FRAME + 37);

        // Reset in the middle of a scan, then the basic scan of 12AF.
        @(negedge clk);
        #1 rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        pulse_load(16'h12AF);
        step(2 * FRAME);

        // Mid-frame load stays pending until the frame boundary.
        wait_k_mod(20);
        pulse_load(16'h1111);
        step(FRAME + FRAME / 2);

        // Load exactly on the frame-wrap edge goes straight to the display.
        wait_k_mod(FRAME - 1);
        pulse_load(16'hBEEF);
        step(FRAME);
        // Two loads in one frame: the second wins.
        wait_k_mod(10);
        pulse_load(16'h5A5A);
        step(5);
        pulse_load(16'hC3D4);
        step(FRAME);

        // Leading-zero suppression, including the dp of a suppressed digit.
        lz_en = 1'b1;
        dp    = 4'b1000;
        pulse_load(16'h0030);
        step(2 * FRAME);
        pulse_load(16'h0000);
        step(2 * FRAME);

        // Blink on digit 0 across several half-periods.
        lz_en      = 1'b0;
        dp         = 4'b0101;
        blink_mask = 4'b0001;
        pulse_load(16'h8421);
        step(6 * FRAME);

        // Brightness extremes and global blank.
        blink_mask = 4'b0000;
        brightness = 2'd0;
        step(FRAME);
        brightness = 2'd1;
        step(FRAME);
        brightness = 2'd3;
        step(FRAME);
        disp_en = 1'b0;
        step(FRAME);
        disp_en = 1'b1;

        // Randomised traffic on every input.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 4))
                    0: value = 16'h0;
                    1: value = 16'($urandom) & 16'h000F;
                    2: value = 16'($urandom) & 16'h00FF;
                    3: value = 16'($urandom) & 16'h0FFF;
                    default: value = 16'($urandom);
                endcase
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            if ($urandom_range(0, 39) == 0) begin
                brightness = BW'($urandom);
                dp         = 4'($urandom);
                lz_en      = 1'($urandom);
                blink_mask = 4'($urandom);
                disp_en    = ($urandom_range(0, 5) != 0);
            end
            step(1);
        end
        load = 1'b0;
        step(2);
        #5;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/scan_display_ctrl.md
Name: scan_display_ctrl

Overview:
Parametrised, time-multiplexed driver for a bank of common-anode 7-segment digits. It replaces the fixed 4-digit, fixed-rate display interface.
- Adds a double-buffered value register, per-digit decimal points, leading-zero suppression, per-digit blink and PWM brightness.
- Sits between the calculator datapath and the board anode/cathode pins.

Parameters:
NUM_DIGITS, 8, digits scanned (1..8).
PRESCALE_LOG2, 11, log2 of clock cycles per digit slot (slot = 2^PRESCALE_LOG2 cycles).
BRIGHT_W, 4, brightness width; must be <= PRESCALE_LOG2.
BLINK_FRAMES_LOG2, 6, log2 of full frames per blink half-period.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
value  in  4*NUM_DIGITS  hex value; nibble i drives digit i (digit 0 rightmost)
load  in  1  capture value into pending buffer
dp  in  NUM_DIGITS  decimal point per digit, active-high
lz_en  in  1  leading-zero suppression enable
blink_mask  in  NUM_DIGITS  1 = digit blinks
brightness  in  BRIGHT_W  duty level; 0 = 1/2^BRIGHT_W, max = full on
disp_en  in  1  0 blanks whole display
digit  out  NUM_DIGITS  anode enables, active-low, registered
segment  out  8  {a,b,c,d,e,f,g,dp}, active-low, registered
pending  out  1  value captured but not yet displayed
frame_start  out  1  one-cycle pulse at start of digit-0 slot

Behaviour:
- Reset (reset=0, async):
  - Prescaler, scan index, blink counter and blink phase go to 0.
  - Active and pending buffers go to 0.
  - pending = 0, frame_start = 0.
  - digit all ones, segment all ones.
- Prescaler cnt:
  - Free-running PRESCALE_LOG2-bit counter that wraps naturally.
  - tick = (cnt == all ones).
- Scan index idx:
  - On tick, idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1.
  - frame_wrap = tick and idx == NUM_DIGITS-1.
- frame_start: registered pulse, high for one cycle in the cycle after frame_wrap.
- Double buffer:
  - load=1 -> pending_buf <= value, pending <= 1.
  - On frame_wrap with pending=1 -> active <= pending_buf, pending <= 0.
  - load and frame_wrap in the same cycle -> active <= value directly, pending <= 0.
  - Repeated loads before a wrap: last one wins.
  - The display never changes mid-frame.
- Blink:
  - On frame_wrap, the blink counter increments.
  - When it wraps to 0 (every 2^BLINK_FRAMES_LOG2 frames), phase toggles.
  - phase=1 is the off phase: digits with blink_mask[idx] set are blanked.
- Leading-zero suppression:
  - Digit i > 0 is blanked when lz_en=1 and nibbles i..NUM_DIGITS-1 of active are all zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - The dp of a suppressed digit is also suppressed.
- Brightness: lit when cnt[PRESCALE_LOG2-1 -: BRIGHT_W] <= brightness.
- Blank condition:
  - blank = !disp_en OR lz-suppressed OR blink-off OR !lit.
  - Blank -> digit all ones, segment all ones.
- Not blank:
  - digit = all ones except bit idx = 0.
  - segment[7:1] = decoded nibble idx of active.
  - segment[0] = ~dp[idx].
- Latency:
  - Outputs are registered, so one clock after cnt/idx.
  - At most one anode is low on any cycle.
- Brightness, dp, lz_en, blink_mask and disp_en are not buffered; they act on the next cycle.

Decomposition:
- Shared package (display_pkg) holds:
  - active-low 16-entry hex segment table;
  - constants SEG_OFF = 8'hFF and DP_BIT = 0;
  - the anode-off constant.
- One sub-module: the existing hex2seg (4-bit number -> 7-bit active-low pattern), instantiated once on the muxed nibble.

Test Plan:
All tests use NUM_DIGITS=4, PRESCALE_LOG2=4, BRIGHT_W=2, BLINK_FRAMES_LOG2=1.
- Reset and scan:
  - Stimulus: reset low mid-scan, then release; load 16'h12AF; brightness 3; disp_en 1.
  - Required: outputs FF/1111 during reset.
  - Required after the next frame: digit sequence 1110, 1101, 1011, 0111, each held 16 cycles; segments decode F, A, 2, 1.
- Double buffer:
  - Stimulus: load 16'h1111 mid-frame.
  - Required: pending=1 and old digits kept until frame_wrap; new value appears in the digit-0 slot; frame_start pulses once.
  - Stimulus: load on the exact frame_wrap cycle.
  - Required: immediate update and pending=0.
- Leading zeros:
  - Stimulus: value 16'h0030, lz_en=1, dp=4'b1000.
  - Required: digits 3 and 2 blanked, dp suppressed, "30" shown.
  - Stimulus: value 0.
  - Required: only digit 0 shows "0".
- Blink:
  - Stimulus: blink_mask 4'b0001.
  - Required: digit 0 blanked in frames 2-3, shown in frames 0-1 and 4-5; other digits always shown.
- Brightness:
  - Stimulus: brightness 0.
  - Required: anode low for cycles with cnt[3:2]==0 (4 of 16) in each slot.
  - Stimulus: brightness 3.
  - Required: low for all 16 cycles.
  - Stimulus: disp_en=0.
  - Required: digit stays 1111.
